tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter: LOCK_FRAMES, default 2, number of consecutive correctly placed sync markers required to declare lock (legal range 1..15).
REQ-002 Ports SHALL be exactly:
  clk       in   1  single clock, all state updates on rising edge
  reset     in   1  synchronous, active-high reset
  G         in   1  active-low enable; G=1 freezes all state
  sync      in   1  frame marker, asserted in the cycle carrying the slot-0 bit
  din       in   1  serial TDM data, one bit per enabled cycle, slots 0..3
  C         out  2  slot index of the bit expected next
  X         out  4  recovered channel bits, X[i] = bit received in slot i
  valid     out  1  one-cycle pulse when X is updated
  locked    out  1  high while in state LOCKED
  sync_err  out  1  one-cycle pulse on a sync framing violation
REQ-003 One clock (clk); reset is synchronous and active-high; all outputs SHALL be registered.

Function
REQ-004 FSM states SHALL be HUNT, CHECK and LOCKED; locked = (state == LOCKED).
REQ-005 Enabled cycle = clock edge with reset=0 and G=0; on any other edge with reset=0, all state, C and X SHALL hold, and valid and sync_err SHALL be 0.
REQ-006 HUNT: C SHALL stay 0; on enabled cycle with sync=1, din SHALL be captured into shadow[0], C SHALL go to 1, good_cnt SHALL go to 1, and the next state SHALL be LOCKED if LOCK_FRAMES=1, else CHECK.
REQ-007 HUNT: sync=0 SHALL leave state unchanged; sync_err SHALL never pulse in HUNT.
REQ-008 CHECK/LOCKED: C SHALL increment modulo 4 on every enabled cycle (3 wraps to 0), and din SHALL be captured into shadow[C].
REQ-009 A sync violation is sync=1 with C!=0, or sync=0 with C==0, on an enabled cycle in CHECK or LOCKED.
REQ-010 On a violation: sync_err=1 for the next cycle; state->HUNT; C->0; good_cnt->0; X held; valid=0 (no partial frame SHALL be emitted).
REQ-011 CHECK: sync=1 with C==0 SHALL increment good_cnt; when the new count equals LOCK_FRAMES, state->LOCKED. That cycle's din SHALL be slot 0 of the first locked frame.
REQ-012 CHECK: X SHALL NOT update and valid SHALL stay 0.
REQ-013 LOCKED: on the enabled cycle with C==3 and no violation, X SHALL load {din, shadow[2], shadow[1], shadow[0]}, and valid SHALL be 1 for exactly the following cycle.
REQ-014 Latency: slot-3 bit sampled at edge N -> X and valid visible after edge N; valid pulses at most once per 4 enabled cycles.
REQ-015 good_cnt SHALL saturate at LOCK_FRAMES and SHALL be 4 bits wide.
REQ-016 In LOCKED, a sync violation takes priority over frame completion at C==3 (not possible by REQ-009, because C==3 with sync=1 is a violation: X held, no valid).

Reset
REQ-017 reset=1 SHALL dominate G and every other input: next edge gives state=HUNT, C=0, X=0, shadow=0, good_cnt=0, valid=0, locked=0, sync_err=0.
REQ-018 Reset mid-frame SHALL discard the partial frame; no valid SHALL be generated for it.

Verification
REQ-019 Reset, G=0, LOCK_FRAMES=2, sync every 4th cycle, frames din=1,0,0,0 then 0,1,0,1 -> locked rises after the second sync; the first locked frame gives X=4'b0001 with a valid pulse, then X=4'b1010 with a valid pulse 4 cycles later.
REQ-020 While locked, G=1 for 3 cycles after slot 1 -> C, X, locked frozen and valid=0; G=0 again -> frame completes with the correct X, and valid occurs 3 cycles later than nominal.
REQ-021 While locked, sync=1 at C=2 -> sync_err pulses 1 cycle, locked=0, C=0, X retains its previous value, and no valid.
REQ-022 In CHECK, sync=0 when C==0 -> sync_err pulse, state HUNT, and no valid ever issued.
REQ-023 reset=1 with G=1 mid-frame in LOCKED, with X=4'b1111 -> after one edge X=4'b0000, C=0, locked=0, valid=0, sync_err=0.
REQ-024 LOCK_FRAMES=1: a single sync in HUNT -> locked high on the next cycle; the first valid comes 4 enabled cycles after the sync.

Source files
------------

// File: rtl/tdm_demux.sv
// Serial 4-slot TDM demultiplexer with sync-marker framing and lock detection.
// A frame is four enabled cycles; slot 0 carries the sync marker. Once enough
// consecutive correctly placed markers have been seen, completed frames are
// presented on X with a one-cycle valid pulse.
module tdm_demux #(
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       G,
  input  logic       sync,
  input  logic       din,
  output logic [1:0] C,
  output logic [3:0] X,
  output logic       valid,
  output logic       locked,
  output logic       sync_err
);

  typedef enum logic [1:0] {StHunt, StCheck, StLocked} state_e;

  localparam logic [3:0] LockCnt = 4'(LOCK_FRAMES);

  state_e     state_q, state_d;
  logic [1:0] c_q, c_d;
  logic [3:0] x_q, x_d;
  // Slots 0..2 of the frame in flight; slot 3 goes straight into X.
  logic [2:0] shadow_q, shadow_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic       valid_q, valid_d;
  logic       sync_err_q, sync_err_d;
  logic       locked_q, locked_d;
  logic       violation;

  // Next-state, framing check and frame assembly.
  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    x_d        = x_q;
    shadow_d   = shadow_q;
    good_cnt_d = good_cnt_q;
    valid_d    = 1'b0;
    sync_err_d = 1'b0;
    violation  = 1'b0;

    if (!G) begin
      unique case (state_q)
        StHunt: begin
          if (sync) begin
            shadow_d[0] = din;
            c_d         = 2'd1;
            good_cnt_d  = 4'd1;
            state_d     = (LockCnt == 4'd1) ? StLocked : StCheck;
          end
        end
        StCheck, StLocked: begin
          // Marker must be present exactly in slot 0.
          violation = (sync != (c_q == 2'd0));
          if (violation) begin
            sync_err_d = 1'b1;
            state_d    = StHunt;
            c_d        = 2'd0;
            good_cnt_d = 4'd0;
          end else begin
            unique case (c_q)
              2'd0:    shadow_d[0] = din;
              2'd1:    shadow_d[1] = din;
              2'd2:    shadow_d[2] = din;
              default: ;
            endcase
            c_d = c_q + 2'd1;
            if (state_q == StCheck && c_q == 2'd0) begin
              if (good_cnt_q < LockCnt) good_cnt_d = good_cnt_q + 4'd1;
              if (good_cnt_d == LockCnt) state_d = StLocked;
            end
            if (state_q == StLocked && c_q == 2'd3) begin
              x_d     = {din, shadow_q};
              valid_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = StHunt;
          c_d     = 2'd0;
        end
      endcase
    end
  end

  // locked is registered alongside the state so every output comes from a flop.
  always_comb begin
    locked_d = (state_d == StLocked);
  end

  // State registers with synchronous reset dominating every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StHunt;
      c_q        <= 2'd0;
      x_q        <= 4'd0;
      shadow_q   <= 3'd0;
      good_cnt_q <= 4'd0;
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      x_q        <= x_d;
      shadow_q   <= shadow_d;
      good_cnt_q <= good_cnt_d;
      valid_q    <= valid_d;
      sync_err_q <= sync_err_d;
      locked_q   <= locked_d;
    end
  end

  assign C        = c_q;
  assign X        = x_q;
  assign valid    = valid_q;
  assign locked   = locked_q;
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: two instances (LOCK_FRAMES=2 and 1) share one stimulus
// stream. A frame-level model predicts C/X/locked and the valid/sync_err events.
module tb_tdm_demux;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic G = 1'b0;
  logic sync = 1'b0;
  logic din = 1'b0;

  logic [1:0] c2, c1;
  logic [3:0] x2, x1;
  logic       valid2, valid1, locked2, locked1, err2, err1;

  tdm_demux #(.LOCK_FRAMES(2)) u_dut2 (
    .clk(clk), .reset(reset), .G(G), .sync(sync), .din(din),
    .C(c2), .X(x2), .valid(valid2), .locked(locked2), .sync_err(err2)
  );

  tdm_demux #(.LOCK_FRAMES(1)) u_dut1 (
    .clk(clk), .reset(reset), .G(G), .sync(sync), .din(din),
    .C(c1), .X(x1), .valid(valid1), .locked(locked1), .sync_err(err1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    bit       err;
    bit [3:0] x;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  // Model state: mode 0=hunting, 1=checking, 2=locked; pos = slot expected next.
  int       m_mode[2];
  int       m_pos[2];
  int       m_good[2];
  bit [3:0] m_fr[2];
  bit [3:0] m_x[2];
  // Expected values visible after the most recent edge.
  int       e_c[2];
  bit [3:0] e_x[2];
  bit       e_lock[2];

  int cycle = 0;
  int n_cmp = 0;
  int n_fail = 0;
  bit armed = 1'b0;

  function automatic void cmp(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, k, cycle, act, exp);
    end
  endfunction

  function automatic void push_ev(int k, bit err, bit [3:0] x);
    ev_t ev;
    ev.cyc = cycle + 1;
    ev.err = err;
    ev.x   = x;
    if (k == 0) q0.push_back(ev);
    else q1.push_back(ev);
  endfunction

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ev_t qfront(int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void qpop(int k);
    if (k == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endfunction

  // Frame-level reference: marker must sit in slot 0, frames count toward lock,
  // only frames started while locked are delivered.
  function automatic void model(int k, int lf, bit r, bit g, bit s, bit d);
    if (r) begin
      m_mode[k] = 0; m_pos[k] = 0; m_good[k] = 0; m_fr[k] = 4'd0; m_x[k] = 4'd0;
    end else if (!g) begin
      if (m_mode[k] == 0) begin
        if (s) begin
          m_fr[k][0] = d;
          m_pos[k]   = 1;
          m_good[k]  = 1;
          m_mode[k]  = (lf == 1) ? 2 : 1;
        end
      end else if (s != (m_pos[k] == 0)) begin
        push_ev(k, 1'b1, 4'd0);
        m_mode[k] = 0; m_pos[k] = 0; m_good[k] = 0;
      end else begin
        m_fr[k][m_pos[k]] = d;
        if (m_mode[k] == 1 && m_pos[k] == 0) begin
          if (m_good[k] < lf) m_good[k]++;
          if (m_good[k] == lf) m_mode[k] = 2;
        end else if (m_mode[k] == 2 && m_pos[k] == 3) begin
          m_x[k] = m_fr[k];
          push_ev(k, 1'b0, m_fr[k]);
        end
        m_pos[k] = (m_pos[k] + 1) % 4;
      end
    end
  endfunction

  task automatic step(input bit r, input bit g, input bit s, input bit d);
    reset = r; G = g; sync = s; din = d;
    model(0, 2, r, g, s, d);
    model(1, 1, r, g, s, d);
    @(posedge clk);
    #1;
    cycle++;
    for (int k = 0; k < 2; k++) begin
      e_c[k]    = m_pos[k];
      e_x[k]    = m_x[k];
      e_lock[k] = (m_mode[k] == 2);
    end
  endtask

  // Sends one frame; bits[i] is the slot-i bit.
  task automatic frame(input bit [3:0] bits);
    step(1'b0, 1'b0, 1'b1, bits[0]);
    for (int i = 1; i < 4; i++) step(1'b0, 1'b0, 1'b0, bits[i]);
  endtask

  task automatic check_inst(input int k, input logic [1:0] c, input logic [3:0] x,
                            input logic v, input logic e, input logic l);
    ev_t ev;
    cmp("C", k, 32'(c), 32'(e_c[k]));
    cmp("X", k, 32'(x), 32'(e_x[k]));
    cmp("locked", k, 32'(l), 32'(e_lock[k]));
    while (qsize(k) > 0 && qfront(k).cyc < cycle) begin
      ev = qfront(k);
      cmp(ev.err ? "missing sync_err" : "missing valid", k, 32'd0, 32'd1);
      qpop(k);
    end
    if (v === 1'b1 || e === 1'b1) begin
      if (qsize(k) > 0 && qfront(k).cyc == cycle) begin
        ev = qfront(k);
        qpop(k);
        cmp("sync_err", k, 32'(e), 32'(ev.err));
        cmp("valid", k, 32'(v), 32'(!ev.err));
        if (!ev.err) cmp("X at valid", k, 32'(x), 32'(ev.x));
      end else begin
        cmp("unexpected valid/sync_err", k, {30'd0, v, e}, 32'd0);
      end
    end
  endtask

  // Monitor: samples both instances 2 time units after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (armed) begin
        check_inst(0, c2, x2, valid2, err2, locked2);
        check_inst(1, c1, x1, valid1, err1, locked1);
      end
    end
  end

  initial begin
    int ph;
    bit r, g, s;

    // Reset dominates G and other inputs.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    armed = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Hunt sync, then frames 1,0,0,0 and 0,1,0,1 once locked.
    frame(4'b0110);
    frame(4'b0001);
    frame(4'b1010);
    frame(4'b1111);

    // G held high for 3 cycles after slot 1.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Misplaced marker at C=2 while locked.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Missing marker while checking.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    frame(4'b1001);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reason X to 1111, then reset with G=1 mid-frame.
    frame(4'b1111);
    frame(4'b1111);
    frame(4'b1111);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic: mostly well-formed frames with gaps, glitches, resets.
    ph = 0;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      g = ($urandom_range(0, 4) == 0);
      s = (ph == 0);
      if ($urandom_range(0, 29) == 0) s = !s;
      step(r, g, s, 1'($urandom));
      if (r) ph = 0;
      else if (!g) ph = (ph + 1) % 4;
    end

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    cmp("leftover events", 0, 32'(qsize(0)), 32'd0);
    cmp("leftover events", 1, 32'(qsize(1)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
